// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch
// requester and a data (load/store) requester.
//
// Parameters:
//   MEM_LAT   memory read latency in cycles, grant to read data (1..15)
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, contention is resolved round-robin
//                       (requester not served by the previous grant wins);
//                       when undefined, data always beats fetch.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_req, if_addr             fetch request (held until if_valid) / address
//   if_gnt, if_valid, if_rdata  fetch grant pulse, completion pulse, data
//   d_req, d_we, d_addr,
//   d_wdata                     data request (held until d_valid), write
//                               enable, address, store data
//   d_gnt, d_valid, d_rdata     data grant pulse, completion pulse, load data
//   mem_en, mem_we, mem_addr,
//   mem_wdata                   memory access strobe, write strobe, address,
//                               write data
//   mem_rdata                   memory read data, MEM_LAT cycles after mem_en
//   stall                       pipeline hold while any request is unserved

module mem_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IF_BUSY = 2'd1;
  localparam logic [1:0] S_D_BUSY  = 2'd2;

  localparam logic [3:0] LAT_RD = 4'(MEM_LAT);

  logic [1:0] r_state;
  logic [3:0] r_lat_cnt;
  logic       r_d_we;     // current data access is a store
`ifdef ARB_ROUND_ROBIN_EN
  logic       r_rr_ptr;   // 0: fetch favoured, 1: data favoured
`endif

  logic w_idle;
  logic w_done;
  logic w_pick_d;
  logic w_pick_if;

  assign w_idle = (r_state == S_IDLE);
  // Completion cycle is always a busy-state cycle, so a held request can
  // never be re-granted in the cycle its valid pulses.
  assign w_done = !w_idle && (r_lat_cnt == 4'd1);

`ifdef ARB_ROUND_ROBIN_EN
  assign w_pick_d = d_req && (!if_req || r_rr_ptr);
`else
  assign w_pick_d = d_req;
`endif
  assign w_pick_if = if_req && !w_pick_d;

  always_comb begin
    if_gnt    = 1'b0;
    if_valid  = 1'b0;
    if_rdata  = '0;
    d_gnt     = 1'b0;
    d_valid   = 1'b0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall     = 1'b0;
    if (!rst) begin
      if (w_idle) begin
        if (w_pick_d) begin
          d_gnt     = 1'b1;
          mem_en    = 1'b1;
          mem_we    = d_we;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
        end else if (w_pick_if) begin
          if_gnt    = 1'b1;
          mem_en    = 1'b1;
          mem_addr  = if_addr;
        end
      end else if (w_done) begin
        if (r_state == S_IF_BUSY) begin
          if_valid = 1'b1;
          if_rdata = mem_rdata;
        end else begin
          d_valid = 1'b1;
          d_rdata = r_d_we ? '0 : mem_rdata;
        end
      end
      stall = (if_req && !if_valid) || (d_req && !d_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= '0;
      r_d_we    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_rr_ptr  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_d) begin
            r_state   <= S_D_BUSY;
            r_lat_cnt <= d_we ? 4'd1 : LAT_RD;
            r_d_we    <= d_we;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_ptr  <= 1'b0;
`endif
          end else if (w_pick_if) begin
            r_state   <= S_IF_BUSY;
            r_lat_cnt <= LAT_RD;
            r_d_we    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_ptr  <= 1'b1;
`endif
          end
        end
        S_IF_BUSY, S_D_BUSY: begin
          if (r_lat_cnt == 4'd1) begin
            r_state   <= S_IDLE;
            r_lat_cnt <= '0;
          end else begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_lat_cnt <= '0;
        end
      endcase
    end
  end

endmodule
